// File: rtl/key_pkg.sv
// Shared types and constants for the keypad scanner.
// Optional auto-repeat is enabled with KEY_SCAN_REPEAT_EN.
package key_pkg;

    localparam int NUM_COLS   = 4;
    localparam int NUM_ROWS   = 5;
    localparam int KEY_CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } key_state_e;

    // Lowest asserted row wins; code is row*4+col.
    function automatic logic [KEY_CODE_W-1:0] key_code(
        input logic [NUM_ROWS-1:0] rows,
        input logic [1:0]          col
    );
        logic [2:0] r;
        r = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) r = 3'(i);
        end
        return {r, col};
    endfunction

endpackage

// File: rtl/key_col_driver.sv
// Column scan timing: one-hot column drive, sample strobe on the
// last cycle of each column slot, frame-end strobe on column 3.
module key_col_driver
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 10000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic [NUM_COLS-1:0] o_key_out,
    output logic [1:0]          o_col,
    output logic                o_sample,
    output logic                o_frame_end
);

    localparam int SW = $clog2(SCAN_DIV);

    logic [SW-1:0] slot_q;
    logic [1:0]    col_q;

    assign o_sample    = (slot_q == SW'(SCAN_DIV - 1));
    assign o_frame_end = o_sample && (col_q == 2'(NUM_COLS - 1));
    assign o_key_out   = NUM_COLS'(1) << col_q;
    assign o_col       = col_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_q <= '0;
            col_q  <= '0;
        end else if (o_sample) begin
            slot_q <= '0;
            col_q  <= col_q + 2'd1;
        end else begin
            slot_q <= slot_q + SW'(1);
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x5 keypad scanner with frame-based press/release debounce.
// Define KEY_SCAN_REPEAT_EN for auto-repeat while a key is held.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV        = 10000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [NUM_COLS-1:0]   o_key_out,
    input  logic [NUM_ROWS-1:0]   i_key_in,
    output logic [KEY_CODE_W-1:0] o_key_code,
    output logic                  o_key_valid,
    output logic                  o_key_held
);

    if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1)
    begin : g_bad_params
        $error("key_scan: invalid parameters");
    end

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [1:0] col;
    logic       sample;
    logic       frame_end;

    key_col_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_key_out   (o_key_out),
        .o_col       (col),
        .o_sample    (sample),
        .o_frame_end (frame_end)
    );

    logic                  found_q;
    logic [KEY_CODE_W-1:0] cand_q;
    logic                  frame_any;
    logic [KEY_CODE_W-1:0] frame_code;

    // Column 3 is folded in combinationally at frame end.
    assign frame_any  = found_q || (|i_key_in);
    assign frame_code = found_q ? cand_q : key_code(i_key_in, col);

    always_ff @(posedge i_clk) begin
        if (i_rst || frame_end) begin
            found_q <= 1'b0;
            cand_q  <= '0;
        end else if (sample && !found_q && (|i_key_in)) begin
            found_q <= 1'b1;
            cand_q  <= key_code(i_key_in, col);
        end
    end

    key_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [KEY_CODE_W-1:0] lat_q, lat_d;
    logic [KEY_CODE_W-1:0] code_q, code_d;
    logic                  valid_q, valid_d;
    logic                  same;

    assign same = frame_any && (frame_code == lat_q);

`ifdef KEY_SCAN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        code_d  = code_q;
        valid_d = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_any) begin
                        lat_d = frame_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = HELD;
                            code_d  = frame_code;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_DB;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (!same) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(DEBOUNCE_FRAMES - 1)) begin
                        state_d = HELD;
                        code_d  = lat_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_d = (DEBOUNCE_FRAMES == 1) ? IDLE : RELEASE_DB;
                        cnt_d   = (DEBOUNCE_FRAMES == 1) ? '0 : CW'(1);
                    end
`ifdef KEY_SCAN_REPEAT_EN
                    else if (rep_q == RW'(REPEAT_FRAMES - 1)) begin
                        valid_d = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
`endif
                end
                RELEASE_DB: begin
                    if (same) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(DEBOUNCE_FRAMES - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
`ifdef KEY_SCAN_REPEAT_EN
        // Repeat period restarts on every entry to or exit from HELD.
        if (state_q != HELD || state_d != HELD) rep_d = '0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

`ifdef KEY_SCAN_REPEAT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`endif

    assign o_key_code  = code_q;
    assign o_key_valid = valid_q;
    assign o_key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad model, vector table and valid scoreboard.
// Repeat checks are compiled in when KEY_SCAN_REPEAT_EN is defined.
module tb_key_scan;

    localparam int SD = 4;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_out;
    logic [4:0] key_in;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [19:0] keys = '0;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [4:0] exp_q[$];
    int         vtimes[$];
    logic       prev_valid = 1'b0;

    key_scan #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (3),
        .REPEAT_FRAMES   (5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_key_out   (key_out),
        .i_key_in    (key_in),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a pressed key connects its column drive to its row.
    always_comb begin
        key_in = '0;
        for (int c = 0; c < 4; c++) begin
            if (key_out[c]) begin
                for (int r = 0; r < 5; r++) begin
                    if (keys[r*4+c]) key_in[r] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            vtimes.push_back(cyc);
            chk("valid_not_back_to_back", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got code %0d, want none",
                         key_code);
            end else begin
                chk("valid_code", int'(key_code), int'(exp_q.pop_front()));
            end
        end
        prev_valid = key_valid;
    end

    task automatic frames(input int n);
        repeat (n * FR) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [19:0] keys;
        int          nfr;
        int          push;
        int          code;
        logic        held;
    } vec_t;

    vec_t tbl[15];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{20'h00000, 2, -1,  0, 1'b0};
        tbl[1]  = '{20'h00080, 2, -1,  0, 1'b0};
        tbl[2]  = '{20'h00000, 2, -1,  0, 1'b0};
        tbl[3]  = '{20'h00800, 5, 11, 11, 1'b1};
        tbl[4]  = '{20'h00000, 3, -1, 11, 1'b0};
        tbl[5]  = '{20'h02200, 4,  9,  9, 1'b1};
        tbl[6]  = '{20'h00000, 3, -1,  9, 1'b0};
        tbl[7]  = '{20'h80000, 4, 19, 19, 1'b1};
        tbl[8]  = '{20'h00000, 1, -1, 19, 1'b1};
        tbl[9]  = '{20'h80000, 3, -1, 19, 1'b1};
        tbl[10] = '{20'h00000, 3, -1, 19, 1'b0};
        tbl[11] = '{20'h00008, 4,  3,  3, 1'b1};
        tbl[12] = '{20'h40000, 4, -1,  3, 1'b0};
        tbl[13] = '{20'h40000, 2, 18, 18, 1'b1};
        tbl[14] = '{20'h00000, 3, -1, 18, 1'b0};

        rst  = 1'b1;
        keys = '0;
        repeat (2) @(negedge clk);
        chk("rst_key_out",   int'(key_out),   1);
        chk("rst_key_code",  int'(key_code),  0);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_held",  int'(key_held),  0);
        rst = 1'b0;

        for (int k = 0; k < FR; k++) begin
            chk("scan_col", int'(key_out), 1 << (k / SD));
            @(negedge clk);
        end

        for (int i = 0; i < 15; i++) begin
            keys = tbl[i].keys;
            if (tbl[i].push >= 0) exp_q.push_back(5'(tbl[i].push));
            frames(tbl[i].nfr);
            chk($sformatf("v%0d_code", i), int'(key_code), tbl[i].code);
            chk($sformatf("v%0d_held", i), int'(key_held), int'(tbl[i].held));
            chk($sformatf("v%0d_pending", i), exp_q.size(), 0);
        end

        // Long hold of key 16: one press, plus repeats when enabled.
        vtimes.delete();
        keys = 20'h10000;
        exp_q.push_back(5'd16);
`ifdef KEY_SCAN_REPEAT_EN
        repeat (4) exp_q.push_back(5'd16);
`endif
        frames(23);
        chk("hold_code", int'(key_code), 16);
        chk("hold_held", int'(key_held), 1);
        chk("hold_pending", exp_q.size(), 0);
`ifdef KEY_SCAN_REPEAT_EN
        chk("hold_pulses", vtimes.size(), 5);
        for (int i = 1; i < vtimes.size(); i++)
            chk("repeat_gap", vtimes[i] - vtimes[i-1], 80);
`else
        chk("hold_pulses", vtimes.size(), 1);
`endif

        // Reset in the middle of a hold.
        repeat (7) @(negedge clk);
        keys = '0;
        rst  = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_key_out",   int'(key_out),   1);
        chk("midrst_key_code",  int'(key_code),  0);
        chk("midrst_key_valid", int'(key_valid), 0);
        chk("midrst_key_held",  int'(key_held),  0);
        rst = 1'b0;

        // Reset during press debounce discards the partial count.
        keys = 20'h10000;
        frames(2);
        do_reset();
        frames(2);
        chk("dbrst_held", int'(key_held), 0);
        chk("dbrst_code", int'(key_code), 0);
        keys = '0;
        frames(1);
        keys = 20'h10000;
        exp_q.push_back(5'd16);
        frames(3);
        chk("after_rst_code", int'(key_code), 16);
        chk("after_rst_held", int'(key_held), 1);
        chk("final_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
